// File: rtl/spi_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_arb
// Purpose  : Two-requester round-robin arbiter in front of a byte-oriented
//            SPI master. The winner's transaction length is latched at
//            grant time. Bytes are streamed from the requester's tx port,
//            and received bytes are handed back. An idle gap is enforced
//            between consecutive transactions.
// Ports    : clk, rst          - clock / synchronous active-high reset
//            req_i[1:0]        - request level per requester
//            len0_i, len1_i    - transaction byte count (sampled at grant)
//            tx0_i, tx1_i      - current byte offered by each requester
//            tx_pop_o[1:0]     - pulse: current byte consumed, present next
//            rx_byte_o         - last received byte (shared)
//            rx_valid_o[1:0]   - pulse qualifying rx_byte_o for the winner
//            grant_o[1:0]      - one-hot active grant
//            done_o[1:0]       - pulse at transaction end
//            dev_sel_o         - index of the granted requester
//            ena_spi           - enable to the SPI master
//            byte_2_send       - byte driven to the SPI master
//            byte_received     - byte returned by the SPI master
//            end_trans         - SPI master byte-complete level
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_arb #(
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic [3:0] len0_i,
    input  logic [3:0] len1_i,
    input  logic [7:0] tx0_i,
    input  logic [7:0] tx1_i,
    output logic [1:0] tx_pop_o,
    output logic [7:0] rx_byte_o,
    output logic [1:0] rx_valid_o,
    output logic [1:0] grant_o,
    output logic [1:0] done_o,
    output logic       dev_sel_o,
    output logic       ena_spi,
    output logic [7:0] byte_2_send,
    input  logic [7:0] byte_received,
    input  logic       end_trans
);

    // A zero gap would let two transactions touch; clamp to one cycle.
    localparam int c_GAP   = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int c_GAP_W = $clog2(c_GAP + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(c_GAP);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_GRANT = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_GAP_S = 3'd4;

    logic [2:0]         r_state;
    logic               r_last_grant;
    logic               r_winner;
    logic [3:0]         r_len;
    logic [3:0]         r_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_end_q;

    logic               w_pick;
    logic [3:0]         w_pick_len;
    logic [1:0]         w_pick_oh;
    logic [1:0]         w_win_oh;
    logic               w_byte_done;

    // Round-robin: the requester that did not win last time gets first look.
    // Reaching GRANT implies at least one request bit, so the fallback
    // choice is always a live requester (or GRANT bails back to IDLE).
    always_comb begin
        w_pick = 1'b0;
        if (r_last_grant) begin
            w_pick = req_i[0] ? 1'b0 : 1'b1;
        end else begin
            w_pick = req_i[1] ? 1'b1 : 1'b0;
        end
    end

    assign w_pick_len  = w_pick ? len1_i : len0_i;
    assign w_pick_oh   = {w_pick, ~w_pick};
    assign w_win_oh    = {r_winner, ~r_winner};

    // end_trans is a level from the SPI master; only its rising edge marks a
    // freshly completed byte, so a level left high across states is ignored.
    assign w_byte_done = end_trans & ~r_end_q;

    assign byte_2_send = (grant_o == 2'b00) ? 8'h00 : (r_winner ? tx1_i : tx0_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
            r_winner     <= 1'b0;
            r_len        <= 4'd0;
            r_cnt        <= 4'd0;
            r_gap_cnt    <= '0;
            r_end_q      <= 1'b0;
            ena_spi      <= 1'b0;
            grant_o      <= 2'b00;
            dev_sel_o    <= 1'b0;
            rx_byte_o    <= 8'h00;
            tx_pop_o     <= 2'b00;
            rx_valid_o   <= 2'b00;
            done_o       <= 2'b00;
        end else begin
            r_end_q    <= end_trans;
            tx_pop_o   <= 2'b00;
            rx_valid_o <= 2'b00;
            done_o     <= 2'b00;

            case (r_state)
                c_IDLE: begin
                    if (|req_i) begin
                        r_state <= c_GRANT;
                    end
                end

                c_GRANT: begin
                    if (req_i == 2'b00) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_winner  <= w_pick;
                        dev_sel_o <= w_pick;
                        r_len     <= w_pick_len;
                        r_cnt     <= 4'd0;
                        if (w_pick_len == 4'd0) begin
                            // Empty transaction: acknowledge without touching SPI.
                            done_o       <= w_pick_oh;
                            r_last_grant <= w_pick;
                            r_gap_cnt    <= c_GAP_LOAD;
                            r_state      <= c_GAP_S;
                        end else begin
                            grant_o <= w_pick_oh;
                            ena_spi <= 1'b1;
                            r_state <= c_RUN;
                        end
                    end
                end

                c_RUN: begin
                    if (w_byte_done) begin
                        rx_byte_o  <= byte_received;
                        rx_valid_o <= w_win_oh;
                        r_cnt      <= r_cnt + 4'd1;
                        if (r_cnt == r_len - 4'd1) begin
                            // Last byte: no next byte to request from the source.
                            ena_spi <= 1'b0;
                            r_state <= c_DRAIN;
                        end else begin
                            tx_pop_o <= w_win_oh;
                        end
                    end
                end

                c_DRAIN: begin
                    if (!end_trans) begin
                        done_o       <= w_win_oh;
                        r_last_grant <= r_winner;
                        grant_o      <= 2'b00;
                        r_gap_cnt    <= c_GAP_LOAD;
                        r_state      <= c_GAP_S;
                    end
                end

                c_GAP_S: begin
                    if (r_gap_cnt == c_GAP_ONE) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_arb
// Purpose  : Directed self-checking bench for spi_master_arb. A small
//            behavioural SPI master (fixed byte time, two-cycle end_trans
//            level) and per-requester byte tables act as the environment.
//            Monitors log grants, pops, received bytes and done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_arb;

    localparam int GAP      = 4;
    localparam int BYTE_CYC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_i = 2'b00;
    logic [3:0] len0_i = 4'd0;
    logic [3:0] len1_i = 4'd0;
    logic [7:0] tx0_i = 8'h00;
    logic [7:0] tx1_i = 8'h00;
    logic [1:0] tx_pop_o;
    logic [7:0] rx_byte_o;
    logic [1:0] rx_valid_o;
    logic [1:0] grant_o;
    logic [1:0] done_o;
    logic       dev_sel_o;
    logic       ena_spi;
    logic [7:0] byte_2_send;
    logic [7:0] byte_received = 8'h00;
    logic       end_trans = 1'b0;

    always #5 clk = ~clk;

    spi_master_arb #(.GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .len0_i       (len0_i),
        .len1_i       (len1_i),
        .tx0_i        (tx0_i),
        .tx1_i        (tx1_i),
        .tx_pop_o     (tx_pop_o),
        .rx_byte_o    (rx_byte_o),
        .rx_valid_o   (rx_valid_o),
        .grant_o      (grant_o),
        .done_o       (done_o),
        .dev_sel_o    (dev_sel_o),
        .ena_spi      (ena_spi),
        .byte_2_send  (byte_2_send),
        .byte_received(byte_received),
        .end_trans    (end_trans)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Environment state
    logic [7:0] tab0 [16];
    logic [7:0] tab1 [16];
    logic [3:0] idx0 = 4'd0;
    logic [3:0] idx1 = 4'd0;
    logic       clr = 1'b0;
    logic       loopback = 1'b1;
    logic       busy = 1'b0;
    int         mcnt = 0;
    int         hold = 0;
    logic [7:0] cap = 8'h00;
    logic [7:0] pat = 8'h00;

    // Monitors
    int         n_pop0 = 0, n_pop1 = 0, n_rxv0 = 0, n_rxv1 = 0, n_ena = 0;
    int         min_gap = 1000, low_run = 0;
    logic       had_tx = 1'b0, prev_ena = 1'b0;
    logic [1:0] prev_grant = 2'b00;
    logic [7:0] mosi_q [$];
    logic [7:0] rx_q0  [$];
    logic [1:0] grant_q[$];
    logic [1:0] done_q [$];

    always @(negedge clk) begin
        if (clr) begin
            n_pop0 = 0; n_pop1 = 0; n_rxv0 = 0; n_rxv1 = 0; n_ena = 0;
            min_gap = 1000; low_run = 0; had_tx = 1'b0; prev_ena = ena_spi;
            prev_grant = grant_o;
            mosi_q.delete(); rx_q0.delete(); grant_q.delete(); done_q.delete();
            idx0 = 4'd0; idx1 = 4'd0; pat = 8'h00;
        end else begin
            if (tx_pop_o[0]) begin n_pop0++; idx0++; end
            if (tx_pop_o[1]) begin n_pop1++; idx1++; end
            if (rx_valid_o[0]) begin n_rxv0++; rx_q0.push_back(rx_byte_o); end
            if (rx_valid_o[1]) n_rxv1++;
            if (done_o != 2'b00) done_q.push_back(done_o);
            if (grant_o != 2'b00 && prev_grant == 2'b00) grant_q.push_back(grant_o);
            prev_grant = grant_o;
            if (ena_spi) begin
                n_ena++;
                if (!prev_ena && had_tx && low_run < min_gap) min_gap = low_run;
                low_run = 0;
                had_tx = 1'b1;
            end else begin
                low_run++;
            end
            prev_ena = ena_spi;
        end
        tx0_i = tab0[idx0];
        tx1_i = tab1[idx1];
        // Behavioural SPI master: load on ena, BYTE_CYC cycles per byte,
        // then end_trans high for two cycles.
        if (hold > 0) begin
            hold--;
            if (hold == 0) end_trans = 1'b0;
        end else if (busy) begin
            mcnt++;
            if (mcnt == BYTE_CYC) begin
                busy = 1'b0;
                end_trans = 1'b1;
                hold = 2;
                byte_received = loopback ? cap : pat;
                pat++;
                mosi_q.push_back(cap);
            end
        end else if (ena_spi) begin
            busy = 1'b1;
            cap  = byte_2_send;
            mcnt = 0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_i = 2'b11; len0_i = 4'd3; len1_i = 4'd3;
        tab0[0] = 8'hFF; tab1[0] = 8'hEE;
        repeat (3) step();
        n_checks++; if (ena_spi !== 1'b0) begin n_err++; $display("FAIL reset_ena: got %b want 0", ena_spi); end
        n_checks++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        n_checks++; if (byte_2_send !== 8'h00) begin n_err++; $display("FAIL reset_byte_2_send: got %h want 00", byte_2_send); end
        n_checks++; if (tx_pop_o !== 2'b00) begin n_err++; $display("FAIL reset_tx_pop: got %b want 00", tx_pop_o); end
        n_checks++; if (rx_valid_o !== 2'b00) begin n_err++; $display("FAIL reset_rx_valid: got %b want 00", rx_valid_o); end
        n_checks++; if (done_o !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b want 00", done_o); end
        n_checks++; if (rx_byte_o !== 8'h00) begin n_err++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte_o); end
        n_checks++; if (dev_sel_o !== 1'b0) begin n_err++; $display("FAIL reset_dev_sel: got %b want 0", dev_sel_o); end
        req_i = 2'b00;
        rst = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_single();
        logic [7:0] exp [3];
        exp = '{8'hA5, 8'h3C, 8'hF0};
        clear_mon();
        loopback = 1'b1;
        for (int i = 0; i < 3; i++) tab0[i] = exp[i];
        len0_i = 4'd3; req_i = 2'b01;
        for (int i = 0; i < 20 && grant_o == 2'b00; i++) step();
        n_checks++; if (grant_o !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b want 01", grant_o); end
        n_checks++; if (dev_sel_o !== 1'b0) begin n_err++; $display("FAIL single_dev_sel: got %b want 0", dev_sel_o); end
        req_i = 2'b00;
        for (int i = 0; i < 200 && done_q.size() == 0; i++) step();
        repeat (GAP + 4) step();
        n_checks++; if (mosi_q.size() != 3) begin n_err++; $display("FAIL single_mosi_count: got %0d want 3", mosi_q.size()); end
        for (int i = 0; i < 3 && i < mosi_q.size(); i++) begin
            n_checks++; if (mosi_q[i] !== exp[i]) begin n_err++; $display("FAIL single_mosi[%0d]: got %h want %h", i, mosi_q[i], exp[i]); end
        end
        for (int i = 0; i < 3 && i < rx_q0.size(); i++) begin
            n_checks++; if (rx_q0[i] !== exp[i]) begin n_err++; $display("FAIL single_rx[%0d]: got %h want %h", i, rx_q0[i], exp[i]); end
        end
        n_checks++; if (n_pop0 != 2 || n_pop1 != 0) begin n_err++; $display("FAIL single_pops: got %0d/%0d want 2/0", n_pop0, n_pop1); end
        n_checks++; if (n_rxv0 != 3 || n_rxv1 != 0) begin n_err++; $display("FAIL single_rx_valid: got %0d/%0d want 3/0", n_rxv0, n_rxv1); end
        n_checks++; if (done_q.size() != 1 || done_q[0] !== 2'b01) begin n_err++; $display("FAIL single_done: got %0d pulses first %b want 1 of 01", done_q.size(), done_q[0]); end
        n_checks++; if (ena_spi !== 1'b0 || grant_o !== 2'b00) begin n_err++; $display("FAIL single_idle_after: got ena %b grant %b want 0/00", ena_spi, grant_o); end
    endtask

    task automatic test_len0();
        clear_mon();
        len1_i = 4'd0; req_i = 2'b10;
        step();
        n_checks++; if (done_o !== 2'b00) begin n_err++; $display("FAIL len0_done_early: got %b want 00", done_o); end
        step();
        n_checks++; if (done_o !== 2'b10) begin n_err++; $display("FAIL len0_done: got %b want 10", done_o); end
        req_i = 2'b00;
        repeat (GAP + 4) step();
        n_checks++; if (n_ena != 0) begin n_err++; $display("FAIL len0_ena: got %0d high cycles want 0", n_ena); end
        n_checks++; if (done_q.size() != 1) begin n_err++; $display("FAIL len0_done_count: got %0d want 1", done_q.size()); end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g [4];
        logic [7:0] exp_b [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_b = '{8'h11, 8'h22, 8'h11, 8'h22};
        clear_mon();
        tab0[0] = 8'h11; tab1[0] = 8'h22;
        len0_i = 4'd1; len1_i = 4'd1; req_i = 2'b11;
        for (int i = 0; i < 600 && grant_q.size() < 4; i++) step();
        req_i = 2'b00;
        for (int i = 0; i < 200 && done_q.size() < 4; i++) step();
        repeat (GAP + 4) step();
        n_checks++; if (grant_q.size() != 4) begin n_err++; $display("FAIL alt_grant_count: got %0d want 4", grant_q.size()); end
        for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
            n_checks++; if (grant_q[i] !== exp_g[i]) begin n_err++; $display("FAIL alt_grant[%0d]: got %b want %b", i, grant_q[i], exp_g[i]); end
        end
        for (int i = 0; i < 4 && i < mosi_q.size(); i++) begin
            n_checks++; if (mosi_q[i] !== exp_b[i]) begin n_err++; $display("FAIL alt_mosi[%0d]: got %h want %h", i, mosi_q[i], exp_b[i]); end
        end
        for (int i = 0; i < 4 && i < done_q.size(); i++) begin
            n_checks++; if (done_q[i] !== exp_g[i]) begin n_err++; $display("FAIL alt_done[%0d]: got %b want %b", i, done_q[i], exp_g[i]); end
        end
        // Low time between bytes of back-to-back transactions: one DRAIN
        // cycle waiting for end_trans, one DRAIN exit, GAP cycles, IDLE, GRANT.
        n_checks++; if (min_gap != GAP + 4) begin n_err++; $display("FAIL alt_gap: got %0d want %0d", min_gap, GAP + 4); end
    endtask

    task automatic test_drop();
        logic [7:0] exp [4];
        exp = '{8'h01, 8'h82, 8'h43, 8'hC4};
        clear_mon();
        for (int i = 0; i < 4; i++) tab0[i] = exp[i];
        len0_i = 4'd4; req_i = 2'b01;
        for (int i = 0; i < 100 && n_rxv0 < 1; i++) step();
        req_i = 2'b00;
        len0_i = 4'd1;
        for (int i = 0; i < 300 && done_q.size() == 0; i++) step();
        repeat (GAP + 4) step();
        n_checks++; if (mosi_q.size() != 4) begin n_err++; $display("FAIL drop_mosi_count: got %0d want 4", mosi_q.size()); end
        for (int i = 0; i < 4 && i < mosi_q.size(); i++) begin
            n_checks++; if (mosi_q[i] !== exp[i]) begin n_err++; $display("FAIL drop_mosi[%0d]: got %h want %h", i, mosi_q[i], exp[i]); end
        end
        n_checks++; if (n_rxv0 != 4 || n_pop0 != 3) begin n_err++; $display("FAIL drop_pulses: got rx %0d pop %0d want 4/3", n_rxv0, n_pop0); end
        n_checks++; if (done_q.size() != 1 || done_q[0] !== 2'b01) begin n_err++; $display("FAIL drop_done: got %0d pulses first %b want 1 of 01", done_q.size(), done_q[0]); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        for (int i = 0; i < 5; i++) tab0[i] = 8'(8'h10 + i);
        len0_i = 4'd5; req_i = 2'b01;
        for (int i = 0; i < 100 && n_rxv0 < 1; i++) step();
        req_i = 2'b00;
        for (int i = 0; i < 20 && !busy; i++) step();
        rst = 1'b1;
        step();
        n_checks++; if (ena_spi !== 1'b0) begin n_err++; $display("FAIL rstmid_ena: got %b want 0", ena_spi); end
        n_checks++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL rstmid_grant: got %b want 00", grant_o); end
        rst = 1'b0;
        for (int i = 0; i < 50 && (busy || hold != 0); i++) step();
        repeat (GAP + 4) step();
        n_checks++; if (done_q.size() != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_q.size()); end
        n_checks++; if (n_rxv0 != 1) begin n_err++; $display("FAIL rstmid_rx_valid: got %0d want 1", n_rxv0); end
        clear_mon();
        tab1[0] = 8'h5A; tab1[1] = 8'hC3;
        len1_i = 4'd2; req_i = 2'b10;
        for (int i = 0; i < 20 && grant_o == 2'b00; i++) step();
        req_i = 2'b00;
        for (int i = 0; i < 200 && done_q.size() == 0; i++) step();
        repeat (GAP + 4) step();
        n_checks++; if (grant_q.size() != 1 || grant_q[0] !== 2'b10) begin n_err++; $display("FAIL rstmid_regrant: got %0d grants first %b want 1 of 10", grant_q.size(), grant_q[0]); end
        n_checks++; if (mosi_q.size() != 2 || mosi_q[0] !== 8'h5A || mosi_q[1] !== 8'hC3) begin n_err++; $display("FAIL rstmid_mosi: got %0d bytes %h %h want 5A C3", mosi_q.size(), mosi_q[0], mosi_q[1]); end
        n_checks++; if (done_q.size() != 1 || done_q[0] !== 2'b10) begin n_err++; $display("FAIL rstmid_done: got %0d pulses first %b want 1 of 10", done_q.size(), done_q[0]); end
    endtask

    task automatic test_len15();
        clear_mon();
        loopback = 1'b0;
        for (int i = 0; i < 16; i++) tab0[i] = 8'(8'h80 + i);
        len0_i = 4'd15; req_i = 2'b01;
        for (int i = 0; i < 20 && grant_o == 2'b00; i++) step();
        req_i = 2'b00;
        for (int i = 0; i < 1000 && done_q.size() == 0; i++) step();
        repeat (GAP + 4) step();
        n_checks++; if (rx_q0.size() != 15) begin n_err++; $display("FAIL len15_rx_count: got %0d want 15", rx_q0.size()); end
        for (int i = 0; i < 15 && i < rx_q0.size(); i++) begin
            n_checks++; if (rx_q0[i] !== 8'(i)) begin n_err++; $display("FAIL len15_rx[%0d]: got %h want %h", i, rx_q0[i], 8'(i)); end
        end
        n_checks++; if (mosi_q.size() != 15 || mosi_q[14] !== 8'h8E) begin n_err++; $display("FAIL len15_mosi: got %0d bytes last %h want 15 last 8E", mosi_q.size(), mosi_q[14]); end
        n_checks++; if (n_pop0 != 14) begin n_err++; $display("FAIL len15_pops: got %0d want 14", n_pop0); end
        n_checks++; if (done_q.size() != 1 || done_q[0] !== 2'b01) begin n_err++; $display("FAIL len15_done: got %0d pulses first %b want 1 of 01", done_q.size(), done_q[0]); end
        loopback = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tab0[i] = 8'h00;
            tab1[i] = 8'h00;
        end
        test_reset();
        test_single();
        test_len0();
        test_alternate();
        test_drop();
        test_reset_mid();
        test_len15();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/spi_master_arb.md
SPI_MASTER_ARB -- requirements
Module: spi_master_arb

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4, meaning minimum idle clk cycles between two transactions, with ena_spi low and cs high.
REQ-002 SHALL have ports clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have ports rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port req_i, input, 2, per-requester transaction request level.
REQ-005 SHALL have port len0_i / len1_i, input, 4, byte count of each requester's transaction; sampled at grant.
REQ-006 SHALL have port tx0_i / tx1_i, input, 8, current byte to send from each requester.
REQ-007 SHALL have port tx_pop_o, output, 2, one-cycle pulse: byte consumed, requester presents the next byte.
REQ-008 SHALL have port rx_byte_o, output, 8, last received byte, shared by both requesters.
REQ-009 SHALL have port rx_valid_o, output, 2, one-cycle pulse qualifying rx_byte_o for the granted requester.
REQ-010 SHALL have port grant_o, output, 2, one-hot active grant; 00 when none.
REQ-011 SHALL have port done_o, output, 2, one-cycle pulse at transaction end.
REQ-012 SHALL have port dev_sel_o, output, 1, index of the granted requester, for chip-select steering.
REQ-013 SHALL have master-side ports: ena_spi output 1; byte_2_send output 8; byte_received input 8; end_trans input 1.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, RUN, DRAIN, GAP.
REQ-015 IDLE: if any req_i bit is set, SHALL go to GRANT next cycle.
REQ-016 GRANT: SHALL pick the winner round-robin against last_grant; after reset, requester 0 has priority.
REQ-017 GRANT: SHALL latch len and winner, set grant_o and dev_sel_o, and go to RUN.
REQ-018 GRANT, latched len == 0: SHALL pulse done_o for the winner, do no SPI activity, update last_grant, and go to GAP.
REQ-019 RUN: SHALL assert ena_spi and drive byte_2_send combinationally from the granted tx*_i.
REQ-020 byte_done SHALL be the first cycle end_trans is high (end_trans & !end_trans_q).
REQ-021 On byte_done, in the same cycle, SHALL set rx_byte_o <= byte_received and pulse rx_valid_o and tx_pop_o for the granted requester.
REQ-022 On byte_done, SHALL increment the 4-bit byte counter; it cannot wrap because len <= 15.
REQ-023 On byte_done with counter == len-1: SHALL register ena_spi low on the next clk and go to DRAIN.
REQ-024 On byte_done with counter == len-1: SHALL NOT pulse tx_pop_o for the final byte.
REQ-025 DRAIN: SHALL wait until end_trans is low, then pulse done_o, update last_grant, clear grant_o, and go to GAP.
REQ-026 GAP: SHALL hold ena_spi low for GAP_CYCLES cycles, then go to IDLE.
REQ-027 GAP_CYCLES = 0 SHALL be treated as 1.
REQ-028 Dropping req_i mid-transaction SHALL NOT abort the transaction; it runs to len bytes.
REQ-029 len*_i and grant-loser changes after GRANT SHALL be ignored until the next GRANT.
REQ-030 byte_2_send SHALL be 8'h00 whenever grant_o == 00.
REQ-031 When both requesters request continuously, grants SHALL alternate 0,1,0,1.

Reset
REQ-032 When rst is high at a clk edge: state IDLE, ena_spi 0, byte_2_send 0, grant_o 00, tx_pop_o/rx_valid_o/done_o 00, rx_byte_o 0, dev_sel_o 0, counter 0, last_grant = 1 (so requester 0 wins first).
REQ-033 Reset mid-RUN SHALL drop ena_spi on the next edge without pulsing done_o; the attached SPI master then completes its in-flight byte and idles on its own.

Verification
REQ-034 Reset then req_i=01, len0=3, tx0 = A5,3C,F0 -> SPI master loopback sees MOSI bytes A5,3C,F0; exactly 2 tx_pop pulses and 3 rx_valid pulses; one done_o=01; ena_spi low afterwards.
REQ-035 req_i=11 held, len0 = len1 = 1 -> grant order 01,10,01,10; ena_spi low for >= GAP_CYCLES between transactions.
REQ-036 req_i=10, len1=0 -> done_o=10 two cycles after req; ena_spi never high.
REQ-037 req_i=01, len0=4, drop req_i after the first byte -> all 4 bytes still transferred, then done_o=01.
REQ-038 Assert rst during the 2nd byte of a len=5 transfer -> ena_spi 0 next cycle, grant_o 00, no done_o, and a new request is granted normally afterwards.
REQ-039 len0=15, MISO driven with pattern 00..0E -> rx_byte_o sequence 00..0E, counter reaches 14, no wrap.
